// File: rtl/uibi_arbiter.sv
// Round-robin NMASTER-to-NSLAVE bus arbiter with slave timeout and invalid-slave error reporting.
// Latency: slave_req one cycle after request, master_ready with slave_ready; masters wait while another is served.
module uibi_arbiter #(
  parameter int XLEN        = 32,
  parameter int SLAVE_WIDTH = 2,
  parameter int NMASTER     = 3,
  parameter int NSLAVE      = 4,
  parameter int TIMEOUT     = 16
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic [NMASTER-1:0]                              master_req,
  input  logic [NMASTER-1:0]                              master_wen,
  input  logic [NMASTER*3-1:0]                            master_mode,
  input  logic [NMASTER*SLAVE_WIDTH-1:0]                  master_num,
  input  logic [NMASTER*(XLEN-SLAVE_WIDTH)-1:0]           master_addr,
  output logic [NMASTER*XLEN-1:0]                         master_dat_i,
  input  logic [NMASTER*XLEN-1:0]                         master_dat_o,
  output logic [NMASTER-1:0]                              master_ready,
  output logic [NSLAVE-1:0]                               slave_req,
  output logic [NSLAVE-1:0]                               slave_wen,
  output logic [NSLAVE*3-1:0]                             slave_mode,
  output logic [NSLAVE*(XLEN-SLAVE_WIDTH)-1:0]            slave_addr,
  output logic [NSLAVE*XLEN-1:0]                          slave_dat_i,
  input  logic [NSLAVE*XLEN-1:0]                          slave_dat_o,
  input  logic [NSLAVE-1:0]                               slave_ready,
  output logic                                            bus_err,
  output logic [((NMASTER > 1) ? $clog2(NMASTER) : 1)-1:0] err_master
);

  localparam int AW = XLEN - SLAVE_WIDTH;
  localparam int GW = (NMASTER > 1) ? $clog2(NMASTER) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state, state_nxt;
  logic [GW-1:0]          g, g_nxt, ptr, ptr_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic                   err_set, found, done;
  logic                   sel_valid, sel_ready;
  logic [SLAVE_WIDTH-1:0] sel_num;
  logic [XLEN-1:0]        sel_rdat;

  always_comb begin
    state_nxt    = state;
    g_nxt        = g;
    ptr_nxt      = ptr;
    cnt_nxt      = cnt;
    err_set      = 1'b0;
    found        = 1'b0;
    done         = 1'b0;
    sel_ready    = 1'b0;
    sel_rdat     = '0;
    slave_req    = '0;
    slave_wen    = '0;
    slave_mode   = '0;
    slave_addr   = '0;
    slave_dat_i  = '0;
    master_ready = '0;
    master_dat_i = '0;
    sel_num      = master_num[g*SLAVE_WIDTH +: SLAVE_WIDTH];
    sel_valid    = (32'(sel_num) < 32'(NSLAVE));

    if (state == BUSY) begin
      for (int s = 0; s < NSLAVE; s++) begin
        if (sel_valid && (32'(sel_num) == s)) begin
          slave_req[s]                = 1'b1;
          slave_wen[s]                = master_wen[g];
          slave_mode[s*3 +: 3]        = master_mode[g*3 +: 3];
          slave_addr[s*AW +: AW]      = master_addr[g*AW +: AW];
          slave_dat_i[s*XLEN +: XLEN] = master_dat_o[g*XLEN +: XLEN];
          sel_ready                   = slave_ready[s];
          sel_rdat                    = slave_dat_o[s*XLEN +: XLEN];
        end
      end
      // A ready in the last wait cycle still counts as a normal completion.
      done    = !sel_valid || sel_ready || (32'(cnt) == 32'(TIMEOUT - 1));
      err_set = done && !sel_ready;
      for (int m = 0; m < NMASTER; m++) begin
        if (32'(g) == m) begin
          master_ready[m]              = done;
          master_dat_i[m*XLEN +: XLEN] = sel_ready ? sel_rdat : '0;
        end
      end
      if (done) begin
        state_nxt = IDLE;
        ptr_nxt   = (32'(g) == 32'(NMASTER - 1)) ? '0 : g + 1'b1;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end else begin
      for (int i = 0; i < NMASTER; i++) begin
        if (!found && master_req[(32'(ptr) + i) % NMASTER]) begin
          found = 1'b1;
          g_nxt = GW'((32'(ptr) + i) % NMASTER);
        end
      end
      if (found) begin
        state_nxt = BUSY;
        cnt_nxt   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      g          <= '0;
      ptr        <= '0;
      cnt        <= '0;
      bus_err    <= 1'b0;
      err_master <= '0;
    end else begin
      state <= state_nxt;
      g     <= g_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
      if (err_set) begin
        bus_err    <= 1'b1;
        err_master <= g;
      end
    end
  end

endmodule

// File: tb/tb_uibi_arbiter.sv
// Bench for uibi_arbiter: directed vector table, hand-written multi-cycle sequences and a random run vs a reference model.
module tb_uibi_arbiter;
  localparam int XLEN = 32, SW = 2, NM = 3, NS = 4, TO = 16, AW = XLEN - SW, MW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NM-1:0]      master_req, master_wen, master_ready;
  logic [NM*3-1:0]    master_mode;
  logic [NM*SW-1:0]   master_num;
  logic [NM*AW-1:0]   master_addr;
  logic [NM*XLEN-1:0] master_dat_i, master_dat_o;
  logic [NS-1:0]      slave_req, slave_wen, slave_ready;
  logic [NS*3-1:0]    slave_mode;
  logic [NS*AW-1:0]   slave_addr;
  logic [NS*XLEN-1:0] slave_dat_i, slave_dat_o;
  logic               bus_err;
  logic [MW-1:0]      err_master;

  logic [NM*XLEN-1:0] master_dat_i3;
  logic [NM-1:0]      master_ready3;
  logic [2:0]         slave_req3, slave_wen3, slave_ready3;
  logic [8:0]         slave_mode3;
  logic [3*AW-1:0]    slave_addr3;
  logic [3*XLEN-1:0]  slave_dat_i3, slave_dat_o3;
  logic               bus_err3;
  logic [MW-1:0]      err_master3;

  uibi_arbiter #(.XLEN(XLEN), .SLAVE_WIDTH(SW), .NMASTER(NM), .NSLAVE(NS), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .master_req(master_req), .master_wen(master_wen),
    .master_mode(master_mode), .master_num(master_num), .master_addr(master_addr),
    .master_dat_i(master_dat_i), .master_dat_o(master_dat_o), .master_ready(master_ready),
    .slave_req(slave_req), .slave_wen(slave_wen), .slave_mode(slave_mode), .slave_addr(slave_addr),
    .slave_dat_i(slave_dat_i), .slave_dat_o(slave_dat_o), .slave_ready(slave_ready),
    .bus_err(bus_err), .err_master(err_master));

  // Second instance with only three slaves, so that slave number 3 is out of range.
  uibi_arbiter #(.XLEN(XLEN), .SLAVE_WIDTH(SW), .NMASTER(NM), .NSLAVE(3), .TIMEOUT(TO)) dut3 (
    .clk(clk), .rst_n(rst_n), .master_req(master_req), .master_wen(master_wen),
    .master_mode(master_mode), .master_num(master_num), .master_addr(master_addr),
    .master_dat_i(master_dat_i3), .master_dat_o(master_dat_o), .master_ready(master_ready3),
    .slave_req(slave_req3), .slave_wen(slave_wen3), .slave_mode(slave_mode3), .slave_addr(slave_addr3),
    .slave_dat_i(slave_dat_i3), .slave_dat_o(slave_dat_o3), .slave_ready(slave_ready3),
    .bus_err(bus_err3), .err_master(err_master3));

  int n_chk = 0;
  int n_fail = 0;

  logic [NM-1:0]   req_q, wen_q;
  logic [2:0]      mode_q [NM];
  logic [SW-1:0]   num_q  [NM];
  logic [AW-1:0]   addr_q [NM];
  logic [XLEN-1:0] wd_q   [NM];
  logic [XLEN-1:0] sd_q   [NS];
  int              rlat   [NS];
  int              age    [NS];
  bit              noise, rnd;

  typedef struct {
    int              m;
    int              num;
    logic [AW-1:0]   addr;
    logic [2:0]      mode;
    logic            wen;
    logic [XLEN-1:0] wd;
    int              lat;
    logic [XLEN-1:0] rd;
    int              exp_off;
    logic [XLEN-1:0] exp_dat;
    logic            exp_err;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One bus cycle: masters change at the falling edge, the slave model answers, outputs are then stable.
  task automatic step();
    @(negedge clk);
    for (int m = 0; m < NM; m++) begin
      master_req[m]                = req_q[m];
      master_wen[m]                = wen_q[m];
      master_mode[m*3 +: 3]        = mode_q[m];
      master_num[m*SW +: SW]       = num_q[m];
      master_addr[m*AW +: AW]      = addr_q[m];
      master_dat_o[m*XLEN +: XLEN] = wd_q[m];
    end
    #1;
    for (int s = 0; s < NS; s++) begin
      if (slave_req[s]) begin
        slave_ready[s] = (age[s] == rlat[s]);
        age[s]++;
      end else begin
        if (rnd && age[s] != 0) rlat[s] = $urandom_range(0, 19);
        age[s] = 0;
        slave_ready[s] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      slave_dat_o[s*XLEN +: XLEN] = rnd ? $urandom : sd_q[s];
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_q = '0;
    for (int s = 0; s < NS; s++) age[s] = 0;
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(output int who, output logic [XLEN-1:0] dat);
    who = -1;
    dat = '0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (master_ready != '0) begin
        for (int m = 0; m < NM; m++)
          if (master_ready[m]) begin
            who = m;
            dat = master_dat_i[m*XLEN +: XLEN];
          end
        break;
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int who, got, ng, last;
    int drop_c [NM];
    logic [XLEN-1:0] dat;
    logic [NM-1:0] er;
    logic [NM*XLEN-1:0] ed;
    logic [NS-1:0] e_req, e_wen;
    logic [NS*3-1:0] e_mode;
    logic [NS*AW-1:0] e_addr;
    logic [NS*XLEN-1:0] e_sd;
    logic [MW-1:0] em;
    int cur, mage, nxt, s, c;
    bit fin, merr, started;
    int merrm;

    tbl[0] = '{1, 2, 30'h10,       3'b111, 1'b0, 32'h0,        3,  32'hDEADBEEF, 3,  32'hDEADBEEF, 1'b0};
    tbl[1] = '{0, 3, 30'h2A5,      3'b111, 1'b1, 32'hCAFE0001, 99, 32'h12345678, 15, 32'h0,        1'b1};
    tbl[2] = '{2, 1, 30'h3FFFFFFF, 3'b011, 1'b0, 32'h0,        15, 32'hA5A50F0F, 15, 32'hA5A50F0F, 1'b0};
    tbl[3] = '{0, 0, 30'h0,        3'b001, 1'b1, 32'hFFFFFFFF, 0,  32'h00000001, 0,  32'h00000001, 1'b0};
    tbl[4] = '{1, 3, 30'h155,      3'b011, 1'b0, 32'h0,        16, 32'h77777777, 15, 32'h0,        1'b1};

    rst_n = 1'b0;
    noise = 1'b0;
    rnd = 1'b0;
    req_q = '0;
    wen_q = '0;
    slave_ready = '0;
    slave_dat_o = '0;
    slave_ready3 = '0;
    slave_dat_o3 = '0;
    for (int m = 0; m < NM; m++) begin
      mode_q[m] = '0; num_q[m] = '0; addr_q[m] = '0; wd_q[m] = '0;
    end
    for (int k = 0; k < NS; k++) begin
      sd_q[k] = '0; rlat[k] = 0; age[k] = 0;
    end

    step();
    chk("reset_state", {slave_req, slave_wen, slave_mode, slave_addr, slave_dat_i, master_ready,
                        master_dat_i, bus_err, err_master}, '0);
    chk("reset_state3", {slave_req3, slave_wen3, slave_mode3, slave_addr3, slave_dat_i3, master_ready3,
                         master_dat_i3, bus_err3, err_master3}, '0);

    // Directed single transactions from the vector table.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      noise = 1'b1;
      for (int k = 0; k < NS; k++) begin
        rlat[k] = 0;
        sd_q[k] = (k == tbl[v].num) ? tbl[v].rd : ~tbl[v].rd;
      end
      rlat[tbl[v].num] = tbl[v].lat;
      req_q[tbl[v].m]  = 1'b1;
      wen_q[tbl[v].m]  = tbl[v].wen;
      mode_q[tbl[v].m] = tbl[v].mode;
      num_q[tbl[v].m]  = SW'(tbl[v].num);
      addr_q[tbl[v].m] = tbl[v].addr;
      wd_q[tbl[v].m]   = tbl[v].wd;
      step();
      chk("vec_idle", {slave_req, master_ready, master_dat_i}, '0);
      e_req = '0; e_wen = '0; e_mode = '0; e_addr = '0; e_sd = '0;
      e_req[tbl[v].num] = 1'b1;
      e_wen[tbl[v].num] = tbl[v].wen;
      e_mode[tbl[v].num*3 +: 3] = tbl[v].mode;
      e_addr[tbl[v].num*AW +: AW] = tbl[v].addr;
      e_sd[tbl[v].num*XLEN +: XLEN] = tbl[v].wd;
      er = '0; er[tbl[v].m] = 1'b1;
      ed = '0; ed[tbl[v].m*XLEN +: XLEN] = tbl[v].exp_dat;
      got = -1;
      for (int off = 0; off < 40; off++) begin
        step();
        if (off == 0)
          chk("vec_route", {slave_req, slave_wen, slave_mode, slave_addr, slave_dat_i},
                           {e_req, e_wen, e_mode, e_addr, e_sd});
        if (master_ready != '0) begin
          chk("vec_ready", {master_ready, master_dat_i}, {er, ed});
          got = off;
          break;
        end
      end
      chk("vec_latency", got, tbl[v].exp_off);
      req_q = '0;
      step();
      em = tbl[v].exp_err ? MW'(tbl[v].m) : '0;
      chk("vec_err", {bus_err, err_master}, {tbl[v].exp_err, em});
    end
    noise = 1'b0;

    // Out-of-range slave number on the three-slave instance.
    do_reset();
    req_q[2] = 1'b1; num_q[2] = 2'd3; mode_q[2] = 3'b111; addr_q[2] = 30'h44; wd_q[2] = 32'h55AA55AA;
    step();
    chk("inv_idle", {slave_req3, master_ready3}, '0);
    step();
    chk("inv_ready", {master_ready3, master_dat_i3}, {3'b100, 96'h0});
    chk("inv_noslave", {slave_req3, slave_wen3, slave_mode3, slave_addr3, slave_dat_i3}, '0);
    req_q = '0;
    step();
    chk("inv_err", {bus_err3, err_master3}, {1'b1, 2'd2});

    // All masters requesting: strict rotation, one idle cycle between grants.
    do_reset();
    for (int k = 0; k < NS; k++) begin
      rlat[k] = 0; sd_q[k] = 32'h1000 + k;
    end
    for (int m = 0; m < NM; m++) begin
      num_q[m] = SW'(m); mode_q[m] = 3'b111; addr_q[m] = AW'(m); wen_q[m] = 1'b0;
      req_q[m] = 1'b1; drop_c[m] = -1;
    end
    ng = 0; last = 0;
    for (int cy = 0; cy < 60 && ng < 6; cy++) begin
      step();
      if (master_ready != '0) begin
        who = -1;
        for (int m = 0; m < NM; m++) if (master_ready[m]) who = m;
        chk("rr_grant", who, ng % 3);
        if (ng > 0) chk("rr_gap", cy - last, 2);
        else chk("rr_first", cy, 1);
        last = cy;
        ng++;
        if (who >= 0) begin
          req_q[who] = 1'b0;
          drop_c[who] = cy;
        end
      end
      for (int m = 0; m < NM; m++)
        if (!req_q[m] && drop_c[m] < cy) req_q[m] = 1'b1;
    end
    chk("rr_count", ng, 6);
    req_q = '0;

    // Reset in the middle of a pending access.
    do_reset();
    for (int k = 0; k < NS; k++) begin
      rlat[k] = 0; sd_q[k] = 32'hB0 + k;
    end
    req_q[1] = 1'b1; num_q[1] = 2'd0;
    wait_grant(who, dat);
    chk("rst_pre_grant", who, 1);
    req_q[1] = 1'b0;
    step();
    req_q[0] = 1'b1; num_q[0] = 2'd1; rlat[1] = 99;
    step();
    step();
    step();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_abort", {slave_req, slave_wen, slave_mode, slave_addr, slave_dat_i, master_ready,
                      master_dat_i, bus_err, err_master}, '0);
    req_q = '0;
    step();
    step();
    chk("rst_hold", {slave_req, master_ready}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < NS; k++) rlat[k] = 1;
    req_q[1] = 1'b1; num_q[1] = 2'd2;
    req_q[2] = 1'b1; num_q[2] = 2'd3;
    wait_grant(who, dat);
    chk("rst_ptr_zero", who, 1);
    req_q[1] = 1'b0;
    wait_grant(who, dat);
    chk("rst_m2_grant", who, 2);
    chk("rst_m2_data", dat, 32'hB3);
    req_q = '0;

    // Random traffic checked cycle by cycle against a transaction-level model.
    do_reset();
    rnd = 1'b1;
    noise = 1'b1;
    for (int k = 0; k < NS; k++) rlat[k] = $urandom_range(0, 19);
    cur = -1; mage = 0; nxt = 0; merr = 1'b0; merrm = 0;
    for (int cy = 0; cy < 800; cy++) begin
      step();
      e_req = '0; e_wen = '0; e_mode = '0; e_addr = '0; e_sd = '0; er = '0; ed = '0;
      fin = 1'b0; s = 0;
      if (cur >= 0) begin
        s = int'(num_q[cur]);
        e_req[s] = 1'b1;
        e_wen[s] = wen_q[cur];
        e_mode[s*3 +: 3] = mode_q[cur];
        e_addr[s*AW +: AW] = addr_q[cur];
        e_sd[s*XLEN +: XLEN] = wd_q[cur];
        fin = slave_ready[s] || (mage == TO - 1);
        er[cur] = fin;
        if (slave_ready[s]) ed[cur*XLEN +: XLEN] = slave_dat_o[s*XLEN +: XLEN];
      end
      chk("rand_ctrl", {slave_req, master_ready, bus_err, err_master}, {e_req, er, merr, MW'(merrm)});
      chk("rand_data", {slave_wen, slave_mode, slave_addr, slave_dat_i, master_dat_i},
                       {e_wen, e_mode, e_addr, e_sd, ed});
      started = 1'b0;
      if (cur < 0) begin
        for (int i = 0; i < NM; i++) begin
          c = (nxt + i) % NM;
          if (!started && req_q[c]) begin
            started = 1'b1;
            cur = c;
            mage = 0;
          end
        end
        er = '0;
      end else if (fin) begin
        if (!slave_ready[s]) begin
          merr = 1'b1;
          merrm = cur;
        end
        nxt = (cur + 1) % NM;
        req_q[cur] = 1'b0;
        cur = -1;
      end else begin
        mage++;
      end
      for (int m = 0; m < NM; m++) begin
        if (!req_q[m] && !er[m] && $urandom_range(0, 3) == 0) begin
          req_q[m] = 1'b1;
          wen_q[m] = 1'($urandom_range(0, 1));
          case ($urandom_range(0, 2))
            0: mode_q[m] = 3'b111;
            1: mode_q[m] = 3'b011;
            default: mode_q[m] = 3'b001;
          endcase
          num_q[m] = SW'($urandom_range(0, 3));
          addr_q[m] = AW'($urandom);
          wd_q[m] = $urandom;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uibi_arbiter.md
UIBI_ARBITER -- requirements
Module: uibi_arbiter

Interface
REQ-001 Parameters SHALL be, as name, default and meaning:
- XLEN, 32, data width.
- SLAVE_WIDTH, 2, slave-number width.
- NMASTER, 3, number of masters.
- NSLAVE, 4, number of slaves (at most 2^SLAVE_WIDTH).
- TIMEOUT, 16, cycles waited for slave ready.
REQ-002 Ports SHALL be, as name, direction, width and meaning:
- clk, in, 1, single clock, rising edge; reset is asynchronous and active-low.
- rst_n, in, 1, asynchronous active-low reset.
- master_req, in, NMASTER, per-master request.
- master_wen, in, NMASTER, per-master write enable.
- master_mode, in, NMASTER×3, per-master bus mode: 111 full, 011 half, 001 quarter.
- master_num, in, NMASTER×SLAVE_WIDTH, target slave number.
- master_addr, in, NMASTER×(XLEN-SLAVE_WIDTH), in-slave address.
- master_dat_i, out, NMASTER×XLEN, read data to masters.
- master_dat_o, in, NMASTER×XLEN, write data from masters.
- master_ready, out, NMASTER, completion pulse per master.
- slave_req, out, NSLAVE, per-slave request.
- slave_wen, out, NSLAVE, per-slave write enable.
- slave_mode, out, NSLAVE×3, per-slave bus mode.
- slave_addr, out, NSLAVE×(XLEN-SLAVE_WIDTH), per-slave address.
- slave_dat_i, out, NSLAVE×XLEN, write data to slaves.
- slave_dat_o, in, NSLAVE×XLEN, read data from slaves.
- slave_ready, in, NSLAVE, slave completion.
- bus_err, out, 1, sticky error flag.
- err_master, out, clog2(NMASTER), master index of the last error.

Function
REQ-003 A master SHALL hold req, wen, mode, num, addr and dat_o stable from req assertion until the cycle in which its master_ready is 1, and SHALL drop req in the following cycle.
REQ-004 The FSM SHALL have two states, IDLE and BUSY; the FSM state, grant index (g), round-robin pointer (ptr) and wait counter (cnt) are the only state besides the error outputs.
REQ-005 In IDLE with any master_req set, the arbiter SHALL select the first requesting master at or after ptr, modulo NMASTER, latch it as g, clear cnt and enter BUSY on the next edge.
REQ-006 In IDLE with no request, the state SHALL remain IDLE and all slave_req and master_ready SHALL be 0.
REQ-007 In BUSY with master_num[g] < NSLAVE, slave_req[master_num[g]] SHALL be 1.
- That slave's wen, mode, addr and dat_i SHALL be driven combinationally from master g.
- All other slave_req SHALL be 0; non-selected slave data, addr, mode and wen SHALL be 0.
REQ-008 In BUSY, when slave_ready of the selected slave is 1, in that same cycle:
- master_ready[g] = 1 and master_dat_i[g] = that slave's slave_dat_o;
- the next state SHALL be IDLE and ptr SHALL become (g+1) mod NMASTER.
REQ-009 master_dat_i of all non-granted masters, and of master g outside its ready cycle, SHALL be 0.
REQ-010 Access latency SHALL be: request seen in IDLE in cycle 0; slave_req in cycle 1; master_ready in the same cycle as slave_ready. Back-to-back grants SHALL have exactly one IDLE cycle between them.
REQ-011 In BUSY without slave_ready, cnt SHALL increment every cycle.
- When cnt == TIMEOUT-1 without ready, the arbiter SHALL complete that cycle: master_ready[g] = 1, master_dat_i[g] = 0, bus_err set to 1, err_master = g, next state IDLE, ptr = g+1.
- slave_ready arriving in the timeout cycle SHALL win: normal completion, no error.
REQ-012 In BUSY with master_num[g] >= NSLAVE, no slave_req SHALL assert.
- master_ready[g] SHALL pulse in the first BUSY cycle with zero data.
- bus_err SHALL be set and err_master SHALL be g.
REQ-013 slave_ready from a non-selected slave, or received in IDLE, SHALL be ignored.
REQ-014 bus_err SHALL be sticky and cleared only by reset.
REQ-015 A master dropping req while BUSY is illegal; the arbiter SHALL still finish that transaction per REQ-008 or REQ-011.
REQ-016 Mode and address fields SHALL pass through unmodified; byte-lane selection is the slave's job.

Reset
REQ-017 On rst_n = 0, asynchronously: state = IDLE, g = 0, ptr = 0, cnt = 0, bus_err = 0, err_master = 0; all slave_req, master_ready and data outputs SHALL be 0.
REQ-018 Reset asserted mid-BUSY SHALL abort the transaction with no master_ready pulse; after release, arbitration SHALL restart from master 0.

Verification
REQ-019 Single read: master 1 requests num = 2, addr = 0x10, mode = 111; slave 2 returns ready with data 0xDEADBEEF 3 cycles after its slave_req -> slave_req[2] asserted in cycle 1, master_ready[1] = 1 with 0xDEADBEEF in the ready cycle, bus_err = 0.
REQ-020 Round-robin: all three masters request continuously; every slave answers in 1 cycle -> grant order 0, 1, 2, 0, 1, 2; each grant separated by one IDLE cycle.
REQ-021 Timeout: master 0 writes to slave 3, which never answers -> master_ready[0] pulses at cycle 16 after slave_req with data 0; bus_err = 1, err_master = 0.
REQ-022 Invalid slave with NSLAVE = 3: master 2 targets num = 3 -> no slave_req; master_ready[2] pulses in cycle 1 with data 0; bus_err = 1, err_master = 2.
REQ-023 Boundary: slave_ready arrives exactly at cnt == TIMEOUT-1 -> normal data returned, bus_err stays 0.
REQ-024 Reset mid-BUSY: pull rst_n low during a pending access -> all outputs 0 immediately; after release, a request from master 2 is granted normally and ptr restarts at 0.
